// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle adder/subtractor. Processes two WIDTH-bit operands CHUNK bits
//   per clock, least-significant chunk first, with the carry held in a register
//   between chunks. Subtraction is a + ~b + !cin, so the inversion is folded in
//   when the operands are captured. A result appears N = WIDTH/CHUNK cycles
//   after the accept edge and is held until the consumer takes it.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of CHUNK
//   CHUNK      bits per cycle; CHUNK == WIDTH gives one arithmetic cycle
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   a, b, op, cin are valid
//   in_ready   idle and able to accept operands
//   a, b       operands (unsigned or two's complement)
//   op         0 = add, 1 = subtract
//   cin        carry-in (add) / borrow-in (sub)
//   out_valid  sum, cout, ovf are valid
//   out_ready  consumer accepts the result
//   sum        result
//   cout       carry out (add) / not-borrow (sub)
//   ovf        signed two's-complement overflow

module seq_chunk_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned   N    = WIDTH / CHUNK;
   localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   // Operands and result stored as N chunks so the active chunk is a plain
   // array index rather than a computed part-select.
   logic [N-1:0][CHUNK-1:0] a_r;
   logic [N-1:0][CHUNK-1:0] b_r;
   logic [N-1:0][CHUNK-1:0] sum_r;
   logic                    carry;
   logic [CW-1:0]           cnt;
   logic [CHUNK:0]          part;

   // One chunk of the addition: {carry_out, chunk_sum}.
   always_comb begin
      part = {1'b0, a_r[cnt]} + {1'b0, b_r[cnt]} + {{CHUNK{1'b0}}, carry};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         sum_r <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b ^ {WIDTH{op}};
                  carry <= cin ^ op;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum_r[cnt] <= part[CHUNK-1:0];
               carry      <= part[CHUNK];
               if (cnt == LAST) begin
                  cout  <= part[CHUNK];
                  // The top result bit is being produced this cycle, so it is
                  // taken from the chunk adder rather than from sum_r.
                  ovf   <= (a_r[N-1][CHUNK-1] == b_r[N-1][CHUNK-1]) &
                           (part[CHUNK-1] != a_r[N-1][CHUNK-1]);
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_r;

endmodule
